// File: rtl/record_tx_arbiter.sv
// record_tx_arbiter
// Picks one of two 48-bit record FIFOs, reads one record and sends it to a
// byte-wide UART, most significant byte first. Between the two sources the
// choice alternates whenever both have data.
//
// Build option: define RECORD_TX_SYNC_HEADER_EN to send SYNC_BYTE ahead of
// every record (7 bytes per record instead of 6).
//
// Handshakes:
//   FIFO side: recN_rdreq is a single-cycle read strobe. The FIFO is
//     non-showahead, so recN_data is valid on the cycle after the strobe.
//     A strobe is only raised for a non-empty source, and never for both
//     sources together.
//   UART side: tx_dv is a single-cycle send strobe. It is raised only while
//     tx_active is low. tx_byte holds its value until the next send. Each
//     byte is complete when tx_done pulses, and tx_done is only acted on
//     while waiting for that completion.
module record_tx_arbiter #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        rec0_empty,
   input  logic        rec1_empty,
   output logic        rec0_rdreq,
   output logic        rec1_rdreq,
   input  logic [47:0] rec0_data,
   input  logic [47:0] rec1_data,
   output logic        tx_dv,
   output logic [7:0]  tx_byte,
   input  logic        tx_active,
   input  logic        tx_done,
   output logic        busy,
   output logic        last_grant,
   output logic [15:0] rec_count,
   output logic [2:0]  state_dbg
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_LATCH = 3'd2;
   localparam logic [2:0] ST_SEND  = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

`ifdef RECORD_TX_SYNC_HEADER_EN
   localparam logic [2:0] LAST_IDX = 3'd6;
`else
   localparam logic [2:0] LAST_IDX = 3'd5;
`endif

   logic [2:0]  state_q, state_d;
   logic        rd0_q, rd0_d;
   logic        rd1_q, rd1_d;
   logic        tx_dv_q, tx_dv_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        busy_q, busy_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] rec_count_q, rec_count_d;
   logic [47:0] hold_q, hold_d;
   logic [2:0]  byte_idx_q, byte_idx_d;
   logic        grant_sel;
   logic [2:0]  data_idx;
   logic [7:0]  cur_byte;

`ifndef RECORD_TX_SYNC_HEADER_EN
   // Without the header the sync byte has no consumer.
   logic [7:0] unused_sync;
   assign unused_sync = SYNC_BYTE;
`endif

   // Select the byte for the current index: the optional header first, then the data bytes from the top down.
   always_comb begin
      cur_byte = 8'h00;
`ifdef RECORD_TX_SYNC_HEADER_EN
      data_idx = byte_idx_q - 3'd1;
`else
      data_idx = byte_idx_q;
`endif
      case (data_idx)
         3'd0:    cur_byte = hold_q[47:40];
         3'd1:    cur_byte = hold_q[39:32];
         3'd2:    cur_byte = hold_q[31:24];
         3'd3:    cur_byte = hold_q[23:16];
         3'd4:    cur_byte = hold_q[15:8];
         3'd5:    cur_byte = hold_q[7:0];
         default: cur_byte = 8'h00;
      endcase
`ifdef RECORD_TX_SYNC_HEADER_EN
      if (byte_idx_q == 3'd0) cur_byte = SYNC_BYTE;
`endif
   end

   // Next-state and registered-output logic of the arbiter FSM.
   always_comb begin
      state_d      = state_q;
      rd0_d        = 1'b0;
      rd1_d        = 1'b0;
      tx_dv_d      = 1'b0;
      tx_byte_d    = tx_byte_q;
      last_grant_d = last_grant_q;
      rec_count_d  = rec_count_q;
      hold_d       = hold_q;
      byte_idx_d   = byte_idx_q;
      // With both sources ready, take the one not served last. Otherwise take whichever one has data.
      grant_sel    = (!rec0_empty && !rec1_empty) ? ~last_grant_q : rec0_empty;
      case (state_q)
         ST_IDLE: begin
            if (enable && (!rec0_empty || !rec1_empty)) begin
               last_grant_d = grant_sel;
               rd0_d        = ~grant_sel;
               rd1_d        = grant_sel;
               state_d      = ST_READ;
            end
         end
         ST_READ: state_d = ST_LATCH;
         ST_LATCH: begin
            hold_d     = last_grant_q ? rec1_data : rec0_data;
            byte_idx_d = 3'd0;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (!tx_active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = cur_byte;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (tx_done) begin
               byte_idx_d = byte_idx_q + 3'd1;
               if (byte_idx_q == LAST_IDX) begin
                  rec_count_d = rec_count_q + 16'd1;
                  state_d     = ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers. Reset drops any partial record.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         rd0_q        <= 1'b0;
         rd1_q        <= 1'b0;
         tx_dv_q      <= 1'b0;
         tx_byte_q    <= 8'h00;
         busy_q       <= 1'b0;
         last_grant_q <= 1'b1;
         rec_count_q  <= 16'h0000;
         hold_q       <= 48'h0;
         byte_idx_q   <= 3'd0;
      end else begin
         state_q      <= state_d;
         rd0_q        <= rd0_d;
         rd1_q        <= rd1_d;
         tx_dv_q      <= tx_dv_d;
         tx_byte_q    <= tx_byte_d;
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         rec_count_q  <= rec_count_d;
         hold_q       <= hold_d;
         byte_idx_q   <= byte_idx_d;
      end
   end

   assign rec0_rdreq = rd0_q;
   assign rec1_rdreq = rd1_q;
   assign tx_dv      = tx_dv_q;
   assign tx_byte    = tx_byte_q;
   assign busy       = busy_q;
   assign last_grant = last_grant_q;
   assign rec_count  = rec_count_q;
   assign state_dbg  = state_q;

endmodule
